// File: rtl/au_seq_prefix_adder.sv
// Multi-cycle wide adder: one CHUNK-bit parallel-prefix carry unit is reused
// over the operand words, LSB chunk first, with the inter-chunk carry held in a flop.

// Group generate/propagate prefix network: go[j]/po[j] cover bits 0..j.
// ARCH: 0 serial ripple, 1 Brent-Kung, 2 Sklansky.
module AU_prefix_and_or #(
  parameter int N    = 16,
  parameter int ARCH = 2
) (
  input  logic [N-1:0] gi,
  input  logic [N-1:0] pi,
  output logic [N-1:0] go,
  output logic [N-1:0] po
);

  if (ARCH == 0 || N == 1) begin : g_serial
    logic [N-1:0] g_c;
    logic [N-1:0] p_c;
    assign g_c[0] = gi[0];
    assign p_c[0] = pi[0];
    for (genvar i = 1; i < N; i++) begin : g_bit
      assign g_c[i] = gi[i] | (pi[i] & g_c[i-1]);
      assign p_c[i] = pi[i] & p_c[i-1];
    end
    assign go = g_c;
    assign po = p_c;
  end else if (ARCH == 1) begin : g_brent_kung
    localparam int L = $clog2(N);
    logic [N-1:0] g_l [0:2*L];
    logic [N-1:0] p_l [0:2*L];
    assign g_l[0] = gi;
    assign p_l[0] = pi;
    // Up-sweep builds power-of-two spans ending at bit i, down-sweep fills the gaps.
    for (genvar l = 0; l < L; l++) begin : g_up
      for (genvar i = 0; i < N; i++) begin : g_bit
        if (((i + 1) % (2 ** (l + 1))) == 0) begin : g_op
          assign g_l[l+1][i] = g_l[l][i] | (p_l[l][i] & g_l[l][i-(2**l)]);
          assign p_l[l+1][i] = p_l[l][i] & p_l[l][i-(2**l)];
        end else begin : g_pass
          assign g_l[l+1][i] = g_l[l][i];
          assign p_l[l+1][i] = p_l[l][i];
        end
      end
    end
    for (genvar d = 0; d < L; d++) begin : g_down
      localparam int LV = L - 1 - d;
      for (genvar i = 0; i < N; i++) begin : g_bit
        if ((((i + 1) % (2 ** (LV + 1))) == (2 ** LV)) && (i > (2 ** LV))) begin : g_op
          assign g_l[L+d+1][i] = g_l[L+d][i] | (p_l[L+d][i] & g_l[L+d][i-(2**LV)]);
          assign p_l[L+d+1][i] = p_l[L+d][i] & p_l[L+d][i-(2**LV)];
        end else begin : g_pass
          assign g_l[L+d+1][i] = g_l[L+d][i];
          assign p_l[L+d+1][i] = p_l[L+d][i];
        end
      end
    end
    assign go = g_l[2*L];
    assign po = p_l[2*L];
  end else begin : g_sklansky
    localparam int L = $clog2(N);
    logic [N-1:0] g_l [0:L];
    logic [N-1:0] p_l [0:L];
    assign g_l[0] = gi;
    assign p_l[0] = pi;
    for (genvar l = 0; l < L; l++) begin : g_lvl
      for (genvar i = 0; i < N; i++) begin : g_bit
        if (((i >> l) & 1) == 1) begin : g_op
          assign g_l[l+1][i] = g_l[l][i] | (p_l[l][i] & g_l[l][((i>>l)<<l)-1]);
          assign p_l[l+1][i] = p_l[l][i] & p_l[l][((i>>l)<<l)-1];
        end else begin : g_pass
          assign g_l[l+1][i] = g_l[l][i];
          assign p_l[l+1][i] = p_l[l][i];
        end
      end
    end
    assign go = g_l[L];
    assign po = p_l[L];
  end

endmodule

module au_seq_prefix_adder #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16,
  parameter int ARCH  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  localparam int NCH   = WIDTH / CHUNK;
  localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCH - 1);

  if ((WIDTH < 1) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
    $error("au_seq_prefix_adder: WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [WIDTH-1:0] s_q,     s_d;
  logic             co_q,    co_d;

  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic [CHUNK-1:0] g_chunk, p_chunk;
  logic [CHUNK-1:0] go_chunk, po_chunk;
  logic [CHUNK-1:0] sum_chunk;
  logic [CHUNK:0]   c_chain;

  assign a_chunk = a_q[int'(cnt_q)*CHUNK +: CHUNK];
  assign b_chunk = b_q[int'(cnt_q)*CHUNK +: CHUNK];
  assign g_chunk = a_chunk & b_chunk;
  assign p_chunk = a_chunk ^ b_chunk;

  AU_prefix_and_or #(
    .N    (CHUNK),
    .ARCH (ARCH)
  ) u_prefix (
    .gi (g_chunk),
    .pi (p_chunk),
    .go (go_chunk),
    .po (po_chunk)
  );

  // The prefix tree assumes carry-in 0; the held carry is folded in afterwards.
  assign c_chain[0]       = carry_q;
  assign c_chain[CHUNK:1] = go_chunk | (po_chunk & {CHUNK{carry_q}});
  assign sum_chunk        = p_chunk ^ c_chain[CHUNK-1:0];

  always_comb begin
    // NOTE: every *_d gets its hold value first, so no path through the case
    // leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    co_d    = co_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = ci;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        s_d[int'(cnt_q)*CHUNK +: CHUNK] = sum_chunk;
        carry_d = c_chain[CHUNK];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          co_d    = c_chain[CHUNK];
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      co_q    <= co_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign s         = s_q;
  assign co        = co_q;

endmodule

// File: tb/tb_au_seq_prefix_adder.sv
// Bench for au_seq_prefix_adder: directed vectors on a 64/16 instance plus
// randomized handshake traffic on 16/16 and 24/8 instances for every ARCH.
`timescale 1ns/1ps
module tb_au_seq_prefix_adder;

  localparam int NOPS     = 1000;
  localparam int SW_LIMIT = 30000;
  localparam int NCH_M    = 4;
  localparam int N_SW     = 6;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic        ci;
    logic [63:0] s;
    logic        co;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_n_main;
  logic rst_n_sw;

  int n_checks    = 0;
  int n_fail      = 0;
  int sw_done_cnt = 0;

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // {co,s} is simply the (WIDTH+1)-bit value of a+b+ci.
  function automatic logic [64:0] ref_add(input logic [63:0] x, input logic [63:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {64'd0, c};
  endfunction

  // Main 64-bit instance
  logic        m_iv, m_ir, m_ov, m_ordy, m_ci, m_co;
  logic [63:0] m_a, m_b, m_s;

  au_seq_prefix_adder #(
    .WIDTH (64),
    .CHUNK (16),
    .ARCH  (2)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n_main),
    .in_valid  (m_iv),
    .in_ready  (m_ir),
    .a         (m_a),
    .b         (m_b),
    .ci        (m_ci),
    .out_valid (m_ov),
    .out_ready (m_ordy),
    .s         (m_s),
    .co        (m_co)
  );

  task automatic send(input logic [63:0] a_i, input logic [63:0] b_i, input logic ci_i);
    int n;
    n    = 0;
    m_iv = 1'b1;
    m_a  = a_i;
    m_b  = b_i;
    m_ci = ci_i;
    while (!m_ir && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_in_time", 68'(n < 50), 68'd1);
    @(negedge clk);
    m_iv = 1'b0;
    m_a  = {$urandom, $urandom};
    m_b  = {$urandom, $urandom};
    m_ci = 1'($urandom);
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!m_ov && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input string name, input logic [63:0] a_i, input logic [63:0] b_i,
                        input logic ci_i, input logic [64:0] exp);
    int n;
    send(a_i, b_i, ci_i);
    wait_out(n);
    check({name, "_latency"}, 68'(n), 68'(NCH_M));
    check({name, "_flags"}, 68'({m_ov, m_ir}), 68'(2'b10));
    check({name, "_sum"}, 68'({m_co, m_s}), 68'(exp));
  endtask

  initial begin : main_seq
    vec_t        vecs [8];
    logic [63:0] ra, rb;
    logic        rc;
    logic [64:0] exp_x, exp_y;
    int          n, ov_seen;

    m_iv = 1'b0; m_a = '0; m_b = '0; m_ci = 1'b0; m_ordy = 1'b1;
    rst_n_main = 1'b0;
    rst_n_sw   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n_main = 1'b1;
    rst_n_sw   = 1'b1;
    check("reset_state", 68'({m_ir, m_ov, m_co, m_s}), 68'({2'b10, 65'd0}));

    vecs[0] = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'h1, ci: 1'b0, s: 64'h0, co: 1'b1};
    vecs[1] = '{a: 64'h0000_0001_0000_FFFF, b: 64'h1, ci: 1'b1, s: 64'h0000_0001_0001_0001, co: 1'b0};
    vecs[2] = '{a: 64'h0, b: 64'h0, ci: 1'b1, s: 64'h1, co: 1'b0};
    vecs[3] = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'hFFFF_FFFF_FFFF_FFFF, ci: 1'b1,
                s: 64'hFFFF_FFFF_FFFF_FFFF, co: 1'b1};
    vecs[4] = '{a: 64'h8000_0000_0000_0000, b: 64'h8000_0000_0000_0000, ci: 1'b0, s: 64'h0, co: 1'b1};
    vecs[5] = '{a: 64'h0000_0000_FFFF_FFFF, b: 64'h0, ci: 1'b1, s: 64'h0000_0001_0000_0000, co: 1'b0};
    vecs[6] = '{a: 64'h1234_5678_9ABC_DEF0, b: 64'h0FED_CBA9_8765_4321, ci: 1'b0,
                s: 64'h2222_2222_2222_2211, co: 1'b0};
    vecs[7] = '{a: 64'hFFFF_0000_FFFF_0000, b: 64'h0001_0000_0001_0000, ci: 1'b0,
                s: 64'h0000_0001_0000_0000, co: 1'b1};

    // Back-to-back: each new send starts while DONE is still showing, so
    // acceptance must wait for IDLE.
    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ci, {vecs[i].co, vecs[i].s});
    end
    @(negedge clk);
    check("idle_holds_result", 68'({m_ir, m_ov, m_co, m_s}), 68'({2'b10, vecs[7].co, vecs[7].s}));

    for (int i = 0; i < 20; i++) begin
      ra = {$urandom, $urandom};
      rb = (i % 4 == 0) ? ~ra : {$urandom, $urandom};
      rc = 1'($urandom);
      run_op($sformatf("rand%0d", i), ra, rb, rc, ref_add(ra, rb, rc));
    end

    // Backpressure: DONE must hold and ignore in_valid pulses.
    @(negedge clk);
    m_ordy = 1'b0;
    ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rc = 1'b1;
    exp_x = ref_add(ra, rb, rc);
    send(ra, rb, rc);
    wait_out(n);
    check("bp_latency", 68'(n), 68'(NCH_M));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", i), 68'({m_ir, m_ov, m_co, m_s}), 68'({2'b01, exp_x}));
      m_iv = i[0];
      m_a  = {$urandom, $urandom};
      m_b  = {$urandom, $urandom};
    end
    @(negedge clk);
    ra = 64'h0000_0000_0000_FFFF; rb = 64'h0000_0000_0000_0001; rc = 1'b0;
    exp_y = ref_add(ra, rb, rc);
    m_ordy = 1'b1; m_iv = 1'b1; m_a = ra; m_b = rb; m_ci = rc;
    @(negedge clk);
    check("bp_release_idle", 68'({m_ir, m_ov}), 68'(2'b10));
    @(negedge clk);
    m_iv = 1'b0; m_a = '0; m_b = '0; m_ci = 1'b0;
    wait_out(n);
    check("after_bp_latency", 68'(n), 68'(NCH_M));
    check("after_bp_sum", 68'({m_co, m_s}), 68'(exp_y));

    // Reset in the middle of RUN discards the op and clears outputs.
    @(negedge clk);
    send(64'hDEAD_BEEF_0123_4567, 64'h1111_2222_3333_4444, 1'b1);
    @(negedge clk);
    rst_n_main = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs", 68'({m_ir, m_ov, m_co, m_s}), 68'({2'b10, 65'd0}));
    rst_n_main = 1'b1;
    ov_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (m_ov) ov_seen++;
    end
    check("rst_op_discarded", 68'(ov_seen), 68'd0);
    run_op("after_rst", 64'd5, 64'd7, 1'b0, 65'd12);

    for (int k = 0; k < SW_LIMIT + 200 && sw_done_cnt < N_SW; k++) @(negedge clk);
    check("sweeps_finished", 68'(sw_done_cnt), 68'(N_SW));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Configuration sweep: random traffic against the arithmetic reference.
  for (genvar gi = 0; gi < N_SW; gi++) begin : g_sw
    localparam int W   = (gi < 3) ? 16 : 24;
    localparam int C   = (gi < 3) ? 16 : 8;
    localparam int AR  = gi % 3;
    localparam int NCH = W / C;

    logic         iv, ir, ov, ordy, cin, co_w;
    logic [W-1:0] av, bv, s_w;
    logic [64:0]  exp_q [$];
    int           t_q [$];

    au_seq_prefix_adder #(
      .WIDTH (W),
      .CHUNK (C),
      .ARCH  (AR)
    ) u_sw (
      .clk       (clk),
      .rst_n     (rst_n_sw),
      .in_valid  (iv),
      .in_ready  (ir),
      .a         (av),
      .b         (bv),
      .ci        (cin),
      .out_valid (ov),
      .out_ready (ordy),
      .s         (s_w),
      .co        (co_w)
    );

    initial begin : drv
      int          sent;
      bit          acc;
      int          mode;
      logic [63:0] r1, r2;
      iv = 1'b0; av = '0; bv = '0; cin = 1'b0;
      sent = 0; acc = 1'b0;
      wait (rst_n_sw === 1'b1);
      for (int k = 0; k < SW_LIMIT && (sent < NOPS || acc); k++) begin
        @(negedge clk);
        if (acc) begin
          iv  = 1'b0;
          acc = 1'b0;
        end
        if (!iv && sent < NOPS && $urandom_range(0, 3) != 0) begin
          mode = $urandom_range(0, 3);
          r1   = {$urandom, $urandom};
          r2   = {$urandom, $urandom};
          case (mode)
            0: begin av = r1[W-1:0]; bv = r2[W-1:0];  end
            1: begin av = '1;        bv = r2[W-1:0];  end
            2: begin av = r1[W-1:0]; bv = ~r1[W-1:0]; end
            default: begin av = r1[W-1:0]; bv = '0; end
          endcase
          cin = 1'($urandom);
          iv  = 1'b1;
        end
        if (iv && ir) begin
          exp_q.push_back(ref_add(64'(av), 64'(bv), cin));
          t_q.push_back(cyc + 1);
          sent++;
          acc = 1'b1;
        end
      end
      iv = 1'b0;
    end

    initial begin : mon
      int          got, extra, t0;
      logic        prev_ov;
      logic [64:0] act, exp_v;
      got = 0; extra = 0; prev_ov = 1'b0; ordy = 1'b0;
      wait (rst_n_sw === 1'b1);
      for (int k = 0; k < SW_LIMIT && got < NOPS; k++) begin
        @(negedge clk);
        if (ov && !prev_ov && t_q.size() > 0) begin
          t0 = t_q.pop_front();
          check($sformatf("sw%0d_latency", gi), 68'(cyc - t0), 68'(NCH));
        end
        prev_ov = ov;
        ordy = ($urandom_range(0, 1) == 1);
        if (ov && ordy) begin
          act = (65'(co_w) << W) | 65'(s_w);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sw%0d_unrequested: result 0x%0h with no operand outstanding", gi, act);
          end else begin
            exp_v = exp_q.pop_front();
            check($sformatf("sw%0d_sum", gi), 68'(act), 68'(exp_v));
          end
          got++;
        end
      end
      check($sformatf("sw%0d_result_count", gi), 68'(got), 68'(NOPS));
      ordy = 1'b1;
      repeat (2 * (NCH + 2)) begin
        @(negedge clk);
        if (ov) extra++;
      end
      check($sformatf("sw%0d_extra_results", gi), 68'(extra), 68'd0);
      check($sformatf("sw%0d_leftover", gi), 68'(exp_q.size()), 68'd0);
      sw_done_cnt++;
    end
  end

endmodule
